array_prod_dot: RTL and testbench



---
 rtl/array_prod_dot_if.sv | 29 ++
 rtl/array_prod_dot.sv | 135 +++++++++++++
 tb/tb_array_prod_dot.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/array_prod_dot_if.sv
// rtl/array_prod_dot_if.sv - operand/result bundle for the dot-product engine
// The testbench drives the operands through master; the engine uses slave.
interface array_prod_dot_if #(
  parameter int ARRAY_SZ = 8,
  parameter int QN       = 6,
  parameter int QM       = 11
);
  localparam int BITWIDTH     = QN + QM + 1;
  localparam int VEC_BITWIDTH = ARRAY_SZ * BITWIDTH;

  logic [VEC_BITWIDTH-1:0] rowVec;
  logic [VEC_BITWIDTH-1:0] colVec;
  logic                    dataReady;
  logic [BITWIDTH-1:0]     result;

  modport master (
    output rowVec,
    output colVec,
    input  dataReady,
    input  result
  );

  modport slave (
    input  rowVec,
    input  colVec,
    output dataReady,
    output result
  );
endinterface

// File: rtl/array_prod_dot.sv
// rtl/array_prod_dot.sv - sequential signed fixed-point dot product with saturation
// One dot product per reset release; result and dataReady stay put until reset.
module array_prod_dot #(
  parameter int ARRAY_SZ = 8,
  parameter int QN       = 6,
  parameter int QM       = 11
) (
  input  logic          clock,
  input  logic          reset,
  array_prod_dot_if.slave bus
);
  localparam int BITWIDTH     = QN + QM + 1;
  localparam int PROD_W       = 2 * BITWIDTH;
  localparam int ACC_BITWIDTH = PROD_W + $clog2(ARRAY_SZ);
  localparam int IDX_W        = $clog2(ARRAY_SZ);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ARRAY_SZ - 1);
  localparam logic signed [ACC_BITWIDTH-1:0] SAT_MAX =
    {{(ACC_BITWIDTH-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [ACC_BITWIDTH-1:0] SAT_MIN =
    {{(ACC_BITWIDTH-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [PROD_W-1:0]                prod_q, prod_d;
  logic                             prod_vld_q, prod_vld_d;
  logic signed [ACC_BITWIDTH-1:0]   acc_q, acc_d;
  logic [BITWIDTH-1:0]              result_q, result_d;
  logic                             ready_q, ready_d;

  logic [BITWIDTH-1:0]              a_el, b_el;
  logic [PROD_W-1:0]                prod_full;
  logic signed [ACC_BITWIDTH-1:0]   prod_ext;
  logic signed [ACC_BITWIDTH-1:0]   scaled;
  logic [BITWIDTH-1:0]              sat_val;

  always_comb begin
    a_el = '0;
    b_el = '0;
    for (int k = 0; k < ARRAY_SZ; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_el = bus.rowVec[k*BITWIDTH +: BITWIDTH];
        b_el = bus.colVec[k*BITWIDTH +: BITWIDTH];
      end
    end
  end

  // Both operands are sign-extended to the product width, so the low PROD_W
  // bits of the unsigned multiply are the exact two's-complement product.
  assign prod_full = {{BITWIDTH{a_el[BITWIDTH-1]}}, a_el} *
                     {{BITWIDTH{b_el[BITWIDTH-1]}}, b_el};
  assign prod_ext  = {{(ACC_BITWIDTH-PROD_W){prod_q[PROD_W-1]}}, prod_q};

  // Arithmetic shift drops QM fraction bits, rounding toward minus infinity.
  assign scaled = acc_q >>> QM;

  always_comb begin
    sat_val = scaled[BITWIDTH-1:0];
    if (scaled > SAT_MAX) begin
      sat_val = SAT_MAX[BITWIDTH-1:0];
    end else if (scaled < SAT_MIN) begin
      sat_val = SAT_MIN[BITWIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    acc_d      = acc_q;
    result_d   = result_q;
    ready_d    = ready_q;

    if (prod_vld_q) begin
      acc_d = acc_q + prod_ext;
    end

    case (state_q)
      IDLE, RUN: begin
        prod_d     = prod_full;
        prod_vld_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = DRAIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RUN;
        end
      end
      DRAIN: begin
        // First DRAIN cycle folds in the last product; the second publishes.
        if (!prod_vld_q) begin
          result_d = sat_val;
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.dataReady = ready_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_array_prod_dot.sv
// tb/tb_array_prod_dot.sv - directed checks of array_prod_dot
// Expected results are hand-computed Q6.11 dot products.
module tb_array_prod_dot;
  localparam int N  = 8;
  localparam int BW = 18;

  localparam logic [BW-1:0] P_HALF = 18'h00400;
  localparam logic [BW-1:0] P_ONE  = 18'h00800;
  localparam logic [BW-1:0] N_ONE  = 18'h3F800;
  localparam logic [BW-1:0] P_31   = 18'h0F800;
  localparam logic [BW-1:0] N_31   = 18'h30800;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  array_prod_dot_if #(.ARRAY_SZ(N), .QN(6), .QM(11)) bus ();

  array_prod_dot #(.ARRAY_SZ(N), .QN(6), .QM(11)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [N*BW-1:0] fill(input logic [BW-1:0] v);
    logic [N*BW-1:0] r;
    for (int k = 0; k < N; k++) r[k*BW +: BW] = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk({tag, "_rst_ready"}, 32'(bus.dataReady), 32'd0);
    chk({tag, "_rst_result"}, 32'(bus.result), 32'd0);
  endtask

  task automatic release_and_check(input string tag, input logic [BW-1:0] exp);
    @(negedge clock);
    reset = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clock);
      #1;
      if (e == 9) begin
        chk({tag, "_early_ready"}, 32'(bus.dataReady), 32'd0);
        chk({tag, "_early_result"}, 32'(bus.result), 32'd0);
      end
    end
    chk({tag, "_ready"}, 32'(bus.dataReady), 32'd1);
    chk({tag, "_result"}, 32'(bus.result), 32'(exp));
  endtask

  initial begin
    logic [N*BW-1:0] v;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.rowVec = fill(P_HALF);
    bus.colVec = fill(P_ONE);
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ready", 32'(bus.dataReady), 32'd0);
    chk("reset_result", 32'(bus.result), 32'd0);

    // 8 * 0.5 * 1.0 = 4.0
    release_and_check("pos", 18'h02000);
    repeat (20) @(posedge clock);
    #1;
    chk("pos_hold_ready", 32'(bus.dataReady), 32'd1);
    chk("pos_hold_result", 32'(bus.result), 32'h02000);

    pulse_reset("mix");
    bus.rowVec = fill(P_ONE);
    v = '0;
    for (int k = 0; k < N; k++) v[k*BW +: BW] = (k % 2 == 0) ? N_ONE : P_ONE;
    bus.colVec = v;
    release_and_check("mix", 18'h00000);

    pulse_reset("neg");
    bus.colVec = fill(N_ONE);
    release_and_check("neg", 18'h3C000);

    pulse_reset("satp");
    bus.rowVec = fill(P_31);
    bus.colVec = fill(P_31);
    release_and_check("satp", 18'h1FFFF);

    pulse_reset("satn");
    bus.colVec = fill(N_31);
    release_and_check("satn", 18'h20000);

    pulse_reset("trunc_pos");
    v = '0;
    v[BW-1:0] = 18'h00001;
    bus.rowVec = v;
    bus.colVec = v;
    release_and_check("trunc_pos", 18'h00000);

    pulse_reset("trunc_neg");
    v[BW-1:0] = 18'h3FFFF;
    bus.rowVec = v;
    release_and_check("trunc_neg", 18'h3FFFF);

    // Abort a run at edge 4 and restart it.
    pulse_reset("mid");
    bus.rowVec = fill(P_HALF);
    bus.colVec = fill(P_ONE);
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_abort_ready", 32'(bus.dataReady), 32'd0);
    chk("mid_abort_result", 32'(bus.result), 32'd0);
    repeat (2) @(posedge clock);
    release_and_check("mid_restart", 18'h02000);

    // Inputs changed during DONE must not disturb the held result.
    bus.colVec = fill(N_ONE);
    bus.rowVec = fill(P_ONE);
    repeat (5) @(posedge clock);
    #1;
    chk("b2b_hold_ready", 32'(bus.dataReady), 32'd1);
    chk("b2b_hold_result", 32'(bus.result), 32'h02000);
    pulse_reset("b2b");
    release_and_check("b2b_new", 18'h3C000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
